// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / lock-loss reset sequencer. Waits for filtered PLL
//               lock plus a delay, then releases reset stages in order.
// Revision    : 1.0 - initial release
// ============================================================================

module reset_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int NUM_LOCKS    = 2,
    parameter int CNT_W        = 24,
    parameter int LOCK_FILTER  = 16,
    parameter int POR_DELAY    = 100000,
    parameter int RELOCK_DELAY = 1000,
    parameter int STAGE_GAP    = 1000
) (
    input  logic                  slow_clock,
    input  logic                  reset,
    input  logic [NUM_LOCKS-1:0]  lock,
    input  logic                  sw_reset,
    input  logic                  clear_lock_lost,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_released,
    output logic                  lock_lost
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);

    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] c_ST_COUNT     = 2'd1;
    localparam logic [1:0] c_ST_SEQUENCE  = 2'd2;
    localparam logic [1:0] c_ST_RUN       = 2'd3;

    localparam logic [FILT_W-1:0] c_FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  c_POR       = CNT_W'(POR_DELAY);
    localparam logic [CNT_W-1:0]  c_RELOCK    = CNT_W'(RELOCK_DELAY);
    localparam logic [CNT_W-1:0]  c_GAP       = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0]  c_ONE       = CNT_W'(1);

    if ((NUM_STAGES < 1) || (NUM_LOCKS < 1) || (CNT_W < 1) || (CNT_W > 62) ||
        (LOCK_FILTER < 1) || (POR_DELAY < 1) || (RELOCK_DELAY < 1) ||
        (STAGE_GAP < 1) ||
        (longint'(POR_DELAY)    >= (longint'(1) << CNT_W)) ||
        (longint'(RELOCK_DELAY) >= (longint'(1) << CNT_W)) ||
        (longint'(STAGE_GAP)    >= (longint'(1) << CNT_W))) begin : g_bad_params
        $error("reset_sequencer: parameter out of range");
    end

    logic [1:0]            r_state;
    logic [FILT_W-1:0]     r_filt;
    logic [CNT_W-1:0]      r_dly;
    logic [NUM_STAGES-1:0] r_stage;
    logic                  r_all;
    logic                  r_ll;
    logic                  r_first_done;

    logic [1:0]            w_state_nxt;
    logic [FILT_W-1:0]     w_filt_nxt;
    logic [CNT_W-1:0]      w_dly_nxt;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_all_nxt;
    logic                  w_ll_nxt;
    logic                  w_first_done_nxt;
    logic                  w_locked;
    logic [NUM_STAGES-1:0] w_shifted;

    always_comb begin
        w_locked         = &lock;
        w_state_nxt      = r_state;
        w_filt_nxt       = r_filt;
        w_dly_nxt        = r_dly;
        w_stage_nxt      = r_stage;
        w_all_nxt        = r_all;
        w_ll_nxt         = r_ll;
        w_first_done_nxt = r_first_done;

        // Stages release in index order, so the released set is a thermometer
        // code and the next release is a shift-in of a one.
        w_shifted[0] = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_shifted[i] = r_stage[i-1];
        end

        if (clear_lock_lost) begin
            w_ll_nxt = 1'b0;
        end

        if (r_state == c_ST_WAIT_LOCK) begin
            if (!w_locked) begin
                w_filt_nxt = '0;
            end else if (r_filt == c_FILT_LAST) begin
                w_filt_nxt  = '0;
                w_dly_nxt   = r_first_done ? c_RELOCK : c_POR;
                w_state_nxt = c_ST_COUNT;
            end else begin
                w_filt_nxt = r_filt + FILT_W'(1);
            end
        end else if (!w_locked) begin
            w_state_nxt      = c_ST_WAIT_LOCK;
            w_stage_nxt      = '0;
            w_all_nxt        = 1'b0;
            w_ll_nxt         = 1'b1;
            w_filt_nxt       = '0;
            w_dly_nxt        = '0;
            w_first_done_nxt = 1'b1;
        end else if (sw_reset) begin
            w_state_nxt = c_ST_COUNT;
            w_stage_nxt = '0;
            w_all_nxt   = 1'b0;
            w_dly_nxt   = c_RELOCK;
        end else begin
            case (r_state)
                c_ST_COUNT, c_ST_SEQUENCE: begin
                    if (r_dly <= c_ONE) begin
                        w_stage_nxt = w_shifted;
                        if (&w_shifted) begin
                            w_state_nxt      = c_ST_RUN;
                            w_all_nxt        = 1'b1;
                            w_first_done_nxt = 1'b1;
                            w_dly_nxt        = '0;
                        end else begin
                            w_state_nxt = c_ST_SEQUENCE;
                            w_dly_nxt   = c_GAP;
                        end
                    end else begin
                        w_dly_nxt = r_dly - c_ONE;
                    end
                end
                c_ST_RUN: begin
                    w_state_nxt = c_ST_RUN;
                end
                default: begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state      <= c_ST_WAIT_LOCK;
            r_filt       <= '0;
            r_dly        <= '0;
            r_stage      <= '0;
            r_all        <= 1'b0;
            r_ll         <= 1'b0;
            r_first_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_filt       <= w_filt_nxt;
            r_dly        <= w_dly_nxt;
            r_stage      <= w_stage_nxt;
            r_all        <= w_all_nxt;
            r_ll         <= w_ll_nxt;
            r_first_done <= w_first_done_nxt;
        end
    end

    assign stage_rst_n  = r_stage;
    assign all_released = r_all;
    assign lock_lost    = r_ll;

endmodule

`default_nettype wire
